// File: rtl/hamming_pkg.sv
// Shared helpers for the parametrised extended-Hamming (SECDED) encoder/decoder family.
// Codeword position 0 is overall parity; check bits sit at power-of-two positions.
package hamming_pkg;

    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    function automatic int par_w(input int data_w);
        int p;
        p = 1;
        for (int k = 0; k < 31; k++) begin
            if ((1 << p) < data_w + p + 1) p = p + 1;
        end
        return p;
    endfunction

    // Data bit j occupies the j-th non-power-of-two position counting up from 3.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < 2 * j + 8; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j) pos = i;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PAR_W  = par_w(DEF_DATA_W);
    localparam int DEF_CW_W   = DEF_DATA_W + DEF_PAR_W + 1;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended-Hamming codeword.
module hamming_syndrome #(
    parameter int CW_W  = 39,
    parameter int PAR_W = 6
) (
    input  logic [CW_W-1:0]  cw,
    output logic [PAR_W-1:0] syn,
    output logic             par
);

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((i >> k) & 1) == 1) syn[k] = syn[k] ^ cw[i];
            end
        end
        par = ^cw;
    end

endmodule

// File: rtl/hamming_secded_decode.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control and
// saturating per-class error counters.
module hamming_secded_decode
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              vld_p1, vld_p2;
    logic              adv1, adv2;
    logic [CW_W-1:0]   cw_p1;
    logic [PAR_W-1:0]  syn_p1, syn_c;
    logic              par_p1, par_c;

    logic              in_range, fix, single_c, double_c;
    logic [CW_W-1:0]   cw_fix;
    logic [DATA_W-1:0] data_c;

    logic [DATA_W-1:0] data_p2;
    logic              single_p2, double_p2;
    logic [PAR_W-1:0]  syn_p2;
    logic [CNT_W-1:0]  cnt_s, cnt_d;
    logic              hs;

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    hamming_syndrome #(
        .CW_W (CW_W),
        .PAR_W(PAR_W)
    ) u_syndrome (
        .cw (in_cw),
        .syn(syn_c),
        .par(par_c)
    );

    // Stage 1: register codeword, syndrome and overall parity
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else if (adv1) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            cw_p1  <= in_cw;
            syn_p1 <= syn_c;
            par_p1 <= par_c;
        end
    end

    // Syndromes pointing past the codeword are treated as uncorrectable.
    assign in_range = int'(syn_p1) <= CW_W - 1;
    assign fix      = par_p1 && (syn_p1 != '0) && in_range;
    assign single_c = par_p1 && ((syn_p1 == '0) || in_range);
    assign double_c = (syn_p1 != '0) && (!par_p1 || !in_range);

    always_comb begin
        cw_fix = cw_p1;
        for (int i = 1; i < CW_W; i++) begin
            if (fix && int'(syn_p1) == i) cw_fix[i] = ~cw_p1[i];
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        assign data_c[j] = cw_fix[data_pos(j)];
    end

    // Stage 2: register corrected payload and classification
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            single_p2 <= 1'b0;
            double_p2 <= 1'b0;
            syn_p2    <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2   <= data_c;
                single_p2 <= single_c;
                double_p2 <= double_c;
                syn_p2    <= syn_p1;
            end
        end
    end

    assign out_valid      = vld_p2;
    assign out_data       = data_p2;
    assign out_err_single = single_p2;
    assign out_err_double = double_p2;
    assign out_syndrome   = syn_p2;

    assign hs = vld_p2 && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_s <= '0;
            cnt_d <= '0;
        end else if (hs) begin
            if (single_p2 && cnt_s != CNT_MAX) cnt_s <= cnt_s + CNT_W'(1);
            if (double_p2 && cnt_d != CNT_MAX) cnt_d <= cnt_d + CNT_W'(1);
        end
    end

    assign cnt_single = cnt_s;
    assign cnt_double = cnt_d;

endmodule

// File: tb/tb_hamming_secded_decode.sv
// Randomised and directed bench for hamming_secded_decode against an arithmetic SECDED model.
module tb_hamming_secded_decode;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int PAR_W  = 6;
    localparam int CW_W   = 39;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err_single;
    logic              out_err_double;
    logic [PAR_W-1:0]  out_syndrome;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_single;
    logic [CNT_W-1:0]  cnt_double;

    hamming_secded_decode #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cw         (in_cw),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err_single(out_err_single),
        .out_err_double(out_err_double),
        .out_syndrome  (out_syndrome),
        .cnt_clr       (cnt_clr),
        .cnt_single    (cnt_single),
        .cnt_double    (cnt_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        single;
        logic        dbl;
        logic [5:0]  syn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_s_m = 0;
    int   cnt_d_m = 0;
    bit   last_in_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pow2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] cw;
        int j;
        int s;
        cw = '0;
        j  = 0;
        for (int i = 1; i < 39; i++) begin
            if (!pow2(i)) begin
                cw[i] = d[j];
                j++;
            end
        end
        s = 0;
        for (int i = 1; i < 39; i++) if (cw[i]) s = s ^ i;
        for (int k = 0; k < 6; k++) cw[1 << k] = s[k];
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic exp_t model(input logic [38:0] cw);
        exp_t e;
        logic [38:0] c;
        int s;
        int j;
        bit p;
        s = 0;
        for (int i = 1; i < 39; i++) if (cw[i]) s = s ^ i;
        p = ^cw;
        c = cw;
        e = '0;
        if (s == 0 && p) e.single = 1'b1;
        else if (s != 0 && p && s <= 38) begin
            e.single = 1'b1;
            c[s] = ~c[s];
        end else if (s != 0) e.dbl = 1'b1;
        j = 0;
        for (int i = 1; i < 39; i++) begin
            if (!pow2(i)) begin
                e.data[j] = c[i];
                j++;
            end
        end
        e.syn = s[5:0];
        return e;
    endfunction

    // One clock: sample handshakes before the edge, update model, check after the edge.
    task automatic step();
        exp_t e;
        logic [31:0] sd;
        logic ss, sdb;
        logic [5:0] ssy;
        bit stall, ohs, ihs, r;
        #1;
        r   = rst;
        ihs = in_valid && in_ready && !r;
        ohs = out_valid && out_ready;
        if (!r) chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
        if (!r && q.size() == 0) chk("idle_valid", 64'(out_valid), 64'(0));
        stall = out_valid && !out_ready && !r;
        sd  = out_data;
        ss  = out_err_single;
        sdb = out_err_double;
        ssy = out_syndrome;
        if (r) begin
            q.delete();
            cnt_s_m = 0;
            cnt_d_m = 0;
        end else begin
            if (ohs) begin
                if (q.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_err_single", 64'(out_err_single), 64'(e.single));
                    chk("out_err_double", 64'(out_err_double), 64'(e.dbl));
                    chk("out_syndrome", 64'(out_syndrome), 64'(e.syn));
                    if (e.single && cnt_s_m < 15) cnt_s_m++;
                    if (e.dbl && cnt_d_m < 15) cnt_d_m++;
                end
            end
            if (cnt_clr) begin
                cnt_s_m = 0;
                cnt_d_m = 0;
            end
            if (ihs) q.push_back(model(in_cw));
        end
        last_in_hs = ihs;
        @(posedge clk);
        #1;
        if (stall) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(sd));
            chk("stall_flags", 64'({out_err_single, out_err_double}), 64'({ss, sdb}));
            chk("stall_syn", 64'(out_syndrome), 64'(ssy));
        end
        chk("cnt_single", 64'(cnt_single), 64'(cnt_s_m));
        chk("cnt_double", 64'(cnt_double), 64'(cnt_d_m));
    endtask

    task automatic send_dir(input logic [38:0] cw);
        in_valid  = 1'b1;
        in_cw     = cw;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_cw    = '0;
        chk("lat1_valid", 64'(out_valid), 64'(0));
        step();
        chk("lat2_valid", 64'(out_valid), 64'(1));
    endtask

    function automatic logic [38:0] one_hot(input int n);
        logic [38:0] b;
        b = '0;
        b[n] = 1'b1;
        return b;
    endfunction

    function automatic logic [38:0] rand_word(input int nflip);
        logic [38:0] w;
        int f1, f2;
        w  = encode($urandom);
        f1 = $urandom_range(0, 38);
        f2 = (f1 + 1 + $urandom_range(0, 37)) % 39;
        if (nflip >= 1) w = w ^ one_hot(f1);
        if (nflip >= 2) w = w ^ one_hot(f2);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [38:0] w[8];
        int sent;
        int cyc;
        int n;

        rst = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_flags", 64'({out_err_single, out_err_double}), 64'(0));
        chk("rst_syn", 64'(out_syndrome), 64'(0));
        chk("rst_cnt", 64'({cnt_single, cnt_double}), 64'(0));
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        send_dir('0);
        chk("clean_data", 64'(out_data), 64'(0));
        chk("clean_flags", 64'({out_err_single, out_err_double}), 64'(0));
        chk("clean_syn", 64'(out_syndrome), 64'(0));
        out_ready = 1'b1;
        step();

        send_dir(one_hot(5));
        chk("s5_syn", 64'(out_syndrome), 64'(5));
        chk("s5_data", 64'(out_data), 64'(0));
        chk("s5_single", 64'(out_err_single), 64'(1));
        out_ready = 1'b1;
        step();
        chk("s5_cnt", 64'(cnt_single), 64'(1));

        send_dir(one_hot(0));
        chk("s0_syn", 64'(out_syndrome), 64'(0));
        chk("s0_single", 64'(out_err_single), 64'(1));
        chk("s0_data", 64'(out_data), 64'(0));
        out_ready = 1'b1;
        step();

        send_dir(one_hot(3) | one_hot(5));
        chk("d35_syn", 64'(out_syndrome), 64'(6));
        chk("d35_double", 64'(out_err_double), 64'(1));
        chk("d35_single", 64'(out_err_single), 64'(0));
        chk("d35_data", 64'(out_data), 64'(3));
        out_ready = 1'b1;
        step();
        chk("d35_cnt", 64'(cnt_double), 64'(1));

        // Back-to-back stream with a 5-cycle sink stall mid-stream
        for (int i = 0; i < 8; i++) w[i] = rand_word(int'($urandom_range(0, 2)));
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_cw     = w[sent];
            in_valid  = 1'b1;
            step();
            if (last_in_hs) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 64'(8));
        for (int k = 0; k < 10 && q.size() != 0; k++) step();
        chk("stream_drain", 64'(q.size()), 64'(0));

        // Saturation of the single-error counter
        n = 0;
        for (int k = 0; k < 60 && n < 20; k++) begin
            in_cw    = rand_word(1);
            in_valid = 1'b1;
            step();
            if (last_in_hs) n++;
        end
        in_valid = 1'b0;
        chk("sat_sent", 64'(n), 64'(20));
        for (int k = 0; k < 10 && q.size() != 0; k++) step();
        chk("sat_single", 64'(cnt_single), 64'(15));

        // Clear coinciding with a counted handshake
        send_dir(rand_word(1));
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_single", 64'(cnt_single), 64'(0));
        chk("clr_double", 64'(cnt_double), 64'(0));

        // Reset while stalled with both stages full
        send_dir(rand_word(1));
        out_ready = 1'b1;
        step();
        chk("pre_rst_cnt", 64'(cnt_single), 64'(1));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = rand_word(2);
        step();
        in_cw = rand_word(0);
        step();
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_cnt", 64'({cnt_single, cnt_double}), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_flags", 64'({out_err_single, out_err_double}), 64'(0));
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        step();
        step();
        chk("post_rst_valid", 64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decode.md
# hamming_secded_decode

Pipelined, parametrised SECDED (single-error-correct, double-error-detect) Hamming decoder with valid/ready flow control and saturating error counters. It is the next-generation replacement for the fixed 38→32 combinational decoder. It adds:
- a generic data width;
- an overall-parity bit for double-error detection;
- backpressure;
- per-class error statistics.

It sits on the receive side of any link or memory read path that carries extended-Hamming-encoded words.

## Interface
Parameters:
- DATA_W, 32, payload width (≥ 4).
- CNT_W, 16, width of each error counter.
- PAR_W, derived (localparam), smallest p with 2^p ≥ DATA_W + p + 1. It is 6 for DATA_W = 32.
- CW_W, derived, DATA_W + PAR_W + 1. It is 39 for DATA_W = 32.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_cw is valid.
- in_ready  out  1  decoder accepts in_cw this cycle.
- in_cw  in  CW_W  received codeword.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the output.
- out_data  out  DATA_W  corrected payload.
- out_err_single  out  1  single error found and corrected.
- out_err_double  out  1  uncorrectable error; out_data is not trustworthy.
- out_syndrome  out  PAR_W  raw syndrome, for debug.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  saturating count of corrected words.
- cnt_double  out  CNT_W  saturating count of uncorrectable words.

## Operation
Codeword layout:
- in_cw[0] is the overall parity bit. Even parity holds over all CW_W bits.
- in_cw[i], for i = 1..CW_W-1, is Hamming position i.
- Check bits sit at the power-of-two positions.
- Data bits fill the remaining positions in ascending order: data[0] is at position 3, data[1] at 5, and so on.

Decode terms:
- Syndrome bit k is the XOR of in_cw[i] over all i ≥ 1 with bit k of i set.
- P is the XOR of all CW_W bits.

Classification:
- S = 0, P = 0: clean. Both flags are 0.
- S = 0, P = 1: the overall parity bit flipped. Set out_err_single; the payload is unchanged.
- S ≠ 0, P = 1, S ≤ CW_W-1: flip bit S, then set out_err_single.
- S ≠ 0, P = 1, S > CW_W-1: set out_err_double and apply no correction.
- S ≠ 0, P = 0: set out_err_double and apply no correction.
- In every double case, out_data is the raw payload extracted without correction.
- out_err_single and out_err_double are never both 1.

Counters:
- A counter increments only on an output handshake (out_valid && out_ready) carrying the matching flag.
- Counters saturate at 2^CNT_W-1.
- cnt_clr has priority over an increment in the same cycle. A clear cycle drops any increment that coincides with it.

## Timing
Pipeline:
- Two register stages. Stage 1 registers the codeword, S and P. Stage 2 registers the corrected data and the flags.
- Latency from input handshake to out_valid is 2 cycles with no stalls.
- Throughput is 1 word per cycle.

Flow control:
- adv2 = !v2 || out_ready.
- adv1 = !v1 || adv2.
- in_ready = adv1. It is purely combinational from out_ready and the stage-valid state.
- While out_valid = 1 and out_ready = 0, every output port holds stable.
- in_cw is sampled only when in_valid && in_ready.

Reset (rst = 1):
- Clears v1 and v2, so out_valid = 0.
- Clears out_data, both flags, out_syndrome and both counters to 0.
- Words in flight are discarded, including a reset asserted mid-stall.
- in_ready = 1 in the first cycle after reset.

## Structure
- Package hamming_pkg holds:
  - the function par_w(data_w);
  - the function is_pow2(i);
  - the function data_pos(j), which maps data index j to its codeword position;
  - the localparams derived from these.

  These are shared with the future parametrised encoder.
- Sub-module hamming_syndrome is combinational: in_cw → {S, P}. It is instantiated in stage 1 and reused by the encoder's self-check.
- Counters are implemented inline.

## Test plan
All scenarios use DATA_W = 32 and CW_W = 39.
- Clean word, in_cw = 0 → after 2 cycles: out_data = 0, both flags 0, out_syndrome = 0.
- Single flip at in_cw[5], all other bits 0 → out_syndrome = 5, out_data = 0, out_err_single = 1, cnt_single = 1.
- Single flip at in_cw[0] → out_syndrome = 0, out_err_single = 1, out_data = 0.
- Double flip at in_cw[3] and in_cw[5] → out_syndrome = 6, out_err_double = 1, out_data = 0x3, cnt_double = 1.
- Stream of 8 back-to-back words with out_ready held low for 5 cycles mid-stream → no loss or duplication, order preserved, outputs stable while stalled, in_ready low once both stages are full.
- CNT_W = 4, 20 single-error words → cnt_single = 15. Then:
  - cnt_clr pulsed together with a handshake → counter = 0;
  - rst asserted with words in flight → out_valid = 0 and counters = 0 on the next cycle.
